// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache memory arbiter.
// Owner encoding doubles as the round-robin grant index.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } state_t;

    localparam int   LINE_WORDS       = 4;
    localparam int   BYTE_OFFSET_BITS = 4;
    localparam logic OWN_IC           = 1'b0;
    localparam logic OWN_DC           = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester
// that was not granted last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = last ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line transfers onto a
// single-word memory port as fixed 4-beat bursts.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ic_req,
    input  logic [31:0]  ic_addr,
    output logic         ic_done,
    output logic [127:0] ic_rdata,
    input  logic         dc_req,
    input  logic         dc_we,
    input  logic [31:0]  dc_addr,
    input  logic [127:0] dc_wdata,
    output logic         dc_done,
    output logic [127:0] dc_rdata,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [31:0]  mem_rdata,
    output logic         busy
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_LATENCY - 1);
    localparam logic [1:0] BEAT_LAST = 2'(LINE_WORDS - 1);

    state_t state;
    state_t state_nxt;

    logic                           owner;
    logic                           last_grant;
    logic                           we_q;
    logic [31-BYTE_OFFSET_BITS:0]   base_q;
    logic [LINE_WORDS-1:0][31:0]    wbuf;
    logic [LINE_WORDS-1:0][31:0]    lbuf;
    logic [3:0]                     wait_cnt;
    logic [1:0]                     beat;
    logic [1:0]                     grant;
    logic                           req_any;
    logic                           unused_ok;

    assign req_any   = ic_req | dc_req;
    assign unused_ok = ^{ic_addr[3:0], dc_addr[3:0], grant[0]};

    rr_pick2 u_pick (
        .req   ({dc_req, ic_req}),
        .last  (last_grant),
        .grant (grant)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (req_any) state_nxt = WAIT;
            WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = BURST;
            BURST: if (beat == BEAT_LAST) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
        endcase
    end

    // Request context is latched once in IDLE so later
    // input changes cannot disturb an active burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_IC;
            last_grant <= OWN_DC;
            we_q       <= 1'b0;
            base_q     <= '0;
            wbuf       <= '0;
            lbuf       <= '0;
            wait_cnt   <= 4'd0;
            beat       <= 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_any) begin
                        owner    <= grant[1];
                        base_q   <= grant[1] ? dc_addr[31:4]
                                             : ic_addr[31:4];
                        we_q     <= grant[1] & dc_we;
                        wbuf     <= grant[1] ? dc_wdata : '0;
                        lbuf     <= '0;
                        wait_cnt <= 4'd0;
                        beat     <= 2'd0;
                    end
                end
                WAIT: wait_cnt <= wait_cnt + 4'd1;
                BURST: begin
                    if (!we_q)
                        lbuf[beat] <= mem_rdata;
                    beat <= beat + 2'd1;
                end
                DONE: last_grant <= owner;
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        ic_done   = 1'b0;
        dc_done   = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE, WAIT: ;
            BURST: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {base_q, beat, 2'b00};
                mem_wdata = we_q ? wbuf[beat] : 32'd0;
            end
            DONE: begin
                ic_done = (owner == OWN_IC);
                dc_done = (owner == OWN_DC);
            end
        endcase
    end

    assign ic_rdata = lbuf;
    assign dc_rdata = lbuf;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default latency instance
// plus a MEM_LATENCY=1 instance sharing the same inputs.
module tb_mem_arbiter;

    localparam logic [127:0] L1230 = {32'hEDC3123C, 32'hEDC71238,
                                      32'hEDCB1234, 32'hEDCF1230};
    localparam logic [127:0] L2000 = {32'hDFF3200C, 32'hDFF72008,
                                      32'hDFFB2004, 32'hDFFF2000};
    localparam logic [127:0] L3000 = {32'hCFF3300C, 32'hCFF73008,
                                      32'hCFFB3004, 32'hCFFF3000};
    localparam logic [127:0] L4000 = {32'hBFF3400C, 32'hBFF74008,
                                      32'hBFFB4004, 32'hBFFF4000};

    logic         clk = 1'b0;
    logic         reset;
    logic         ic_req, dc_req, dc_we;
    logic [31:0]  ic_addr, dc_addr;
    logic [127:0] dc_wdata;

    logic         ic_done, dc_done, mem_req, mem_we, busy;
    logic [127:0] ic_rdata, dc_rdata;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;

    logic         ic_done1, dc_done1, mem_req1, mem_we1, busy1;
    logic [127:0] ic_rdata1, dc_rdata1;
    logic [31:0]  mem_addr1, mem_wdata1, mem_rdata1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int at;
    int n_beats1 = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_wdata[$];
    logic        q_we[$];
    int          q_cyc[$];
    logic [31:0] wd [4];

    // Memory returns a pattern derived from its address.
    assign mem_rdata  = {~mem_addr[15:0], mem_addr[15:0]};
    assign mem_rdata1 = {~mem_addr1[15:0], mem_addr1[15:0]};

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr),
        .ic_done(ic_done), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_done(dc_done),
        .dc_rdata(dc_rdata),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr),
        .ic_done(ic_done1), .ic_rdata(ic_rdata1),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_done(dc_done1),
        .dc_rdata(dc_rdata1),
        .mem_req(mem_req1), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    always @(negedge clk) begin
        if (mem_req) begin
            q_addr.push_back(mem_addr);
            q_wdata.push_back(mem_wdata);
            q_we.push_back(mem_we);
            q_cyc.push_back(cyc);
        end
        if (mem_req1)
            n_beats1++;
    end

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        for (int i = 0; i < 64 && cyc < n; i++)
            step();
    endtask

    task automatic begin_req();
        step();
        step();
        cyc = 0;
        q_addr.delete();
        q_wdata.delete();
        q_we.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic run_until(input int sel, input int lim,
                             output int t);
        logic d;
        t = -1;
        for (int i = 0; i < lim; i++) begin
            step();
            case (sel)
                0:       d = ic_done;
                1:       d = dc_done;
                2:       d = ic_done1;
                default: d = dc_done1;
            endcase
            if (d) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk(tag, {mem_req, mem_we, mem_addr, mem_wdata,
                  ic_done, dc_done, busy}, '0);
        chk({tag, "_ic_rdata"}, ic_rdata, '0);
        chk({tag, "_dc_rdata"}, dc_rdata, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang exp finish");
        $fatal(1);
    end

    initial begin
        wd = '{32'h1111_1111, 32'h2222_2222,
               32'h3333_3333, 32'h4444_4444};
        reset = 1'b1;
        ic_req = 0; dc_req = 0; dc_we = 0;
        ic_addr = 0; dc_addr = 0; dc_wdata = 0;
        step();
        step();
        chk_idle_outs("reset");
        reset = 1'b0;

        // I-cache refill
        begin_req();
        ic_addr = 32'h0000_1234;
        ic_req = 1;
        run_until(0, 30, at);
        chk("ic_lat", at, 10);
        chk("ic_line", ic_rdata, L1230);
        chk("ic_dc_quiet", dc_done, 0);
        ic_req = 0;
        chk("ic_nbeats", q_addr.size(), 4);
        for (int i = 0; i < 4 && i < q_addr.size(); i++)
            chk("ic_beat", {32'(q_cyc[i]), q_we[i], q_addr[i]},
                {32'(6 + i), 1'b0, 32'h1230 + 32'(4 * i)});

        // D-cache writeback
        begin_req();
        dc_we = 1;
        dc_addr = 32'h0000_0080;
        dc_wdata = {wd[3], wd[2], wd[1], wd[0]};
        dc_req = 1;
        run_until(1, 30, at);
        chk("dc_wr_lat", at, 10);
        chk("dc_wr_rdata", dc_rdata, '0);
        chk("dc_wr_ic_quiet", ic_done, 0);
        dc_req = 0;
        dc_we = 0;
        chk("dc_wr_nbeats", q_addr.size(), 4);
        for (int i = 0; i < 4 && i < q_addr.size(); i++)
            chk("dc_wr_beat", {q_we[i], q_addr[i], q_wdata[i]},
                {1'b1, 32'h80 + 32'(4 * i), wd[i]});

        // Round-robin alternation from reset
        do_reset();
        begin_req();
        ic_addr = 32'h2000;
        dc_addr = 32'h3000;
        ic_req = 1;
        dc_req = 1;
        run_until(0, 30, at);
        chk("rr_ic_first", at, 10);
        chk("rr_ic_line", ic_rdata, L2000);
        chk("rr_dc_wait", dc_done, 0);
        ic_req = 0;
        run_until(1, 30, at);
        chk("rr_dc_second", at, 21);
        chk("rr_dc_line", dc_rdata, L3000);
        dc_req = 0;
        begin_req();
        ic_req = 1;
        dc_req = 1;
        run_until(0, 30, at);
        chk("rr_ic_again", at, 10);
        ic_req = 0;
        run_until(1, 30, at);
        chk("rr_dc_again", at, 21);
        dc_req = 0;

        // D request arriving mid I-burst
        do_reset();
        begin_req();
        ic_addr = 32'h1234;
        ic_req = 1;
        step_to(7);
        dc_addr = 32'h5000;
        dc_req = 1;
        step_to(8);
        dc_addr = 32'h4000;
        run_until(0, 30, at);
        chk("late_ic_lat", at, 10);
        chk("late_ic_line", ic_rdata, L1230);
        ic_req = 0;
        run_until(1, 30, at);
        chk("late_dc_lat", at, 21);
        chk("late_dc_line", dc_rdata, L4000);
        dc_req = 0;
        chk("late_nbeats", q_addr.size(), 8);
        if (q_addr.size() >= 5)
            chk("late_dc_beat0", {32'(q_cyc[4]), q_addr[4]},
                {32'd17, 32'h4000});

        // Reset during beat 2
        begin_req();
        ic_req = 1;
        step_to(8);
        chk("mid_beat2", {mem_req, mem_addr}, {1'b1, 32'h1238});
        reset = 1;
        step();
        chk_idle_outs("mid_reset");
        ic_req = 0;
        reset = 0;
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                step();
                seen += int'(ic_done | dc_done | busy);
            end
            chk("mid_no_done", seen, 0);
        end
        begin_req();
        ic_req = 1;
        run_until(0, 30, at);
        chk("post_rst_lat", at, 10);
        chk("post_rst_line", ic_rdata, L1230);
        ic_req = 0;

        // MEM_LATENCY = 1 instance
        do_reset();
        n_beats1 = 0;
        begin_req();
        ic_req = 1;
        run_until(2, 30, at);
        chk("lat1_ic", at, 6);
        chk("lat1_ic_line", ic_rdata1, L1230);
        ic_req = 0;
        step_to(16);
        chk("lat1_nbeats", n_beats1, 4);
        begin_req();
        dc_we = 1;
        dc_addr = 32'h80;
        dc_req = 1;
        run_until(3, 30, at);
        chk("lat1_dc", at, 6);
        dc_req = 0;
        dc_we = 0;
        step_to(16);
        chk("lat1_nbeats2", n_beats1, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
